remote_load_latency_hist: RTL and testbench

Synthesizable, parametrised remote-load latency profiler with per-channel statistics and log2 histograms, for silicon bring-up counters in the tile. It sits beside the vanilla core's network_tx. It timestamps every remote load issue, keyed by (channel, tag), and retires the entry when the response is accepted. It accumulates count, latency sum, max latency, outstanding count and a log2 latency histogram per channel. All results are read back through a registered read port.

---
 rtl/remote_load_latency_hist.sv | 209 ++++++++++++++++++++
 tb/tb_remote_load_latency_hist.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_load_latency_hist.sv
// Remote-load latency profiler: timestamps issues per (channel, tag), retires on response,
// and keeps per-channel count/sum/max/outstanding plus a log2 latency histogram.
module remote_load_latency_hist #(
  parameter int unsigned num_chan_p  = 3,
  parameter int unsigned tag_els_p   = 32,
  parameter int unsigned lat_width_p = 16,
  parameter int unsigned ctr_width_p = 32,
  parameter int unsigned hist_bins_p = 8,
  localparam int unsigned chan_w  = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
  localparam int unsigned tag_w   = (tag_els_p > 1) ? $clog2(tag_els_p) : 1,
  localparam int unsigned field_w = $clog2(4 + hist_bins_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   issue_v_i,
  input  logic [chan_w-1:0]      issue_chan_i,
  input  logic [tag_w-1:0]       issue_tag_i,
  input  logic                   resp_v_i,
  input  logic [chan_w-1:0]      resp_chan_i,
  input  logic [tag_w-1:0]       resp_tag_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic                   rd_v_i,
  input  logic [chan_w-1:0]      rd_chan_i,
  input  logic [field_w-1:0]     rd_field_i,
  output logic                   rd_v_o,
  output logic [ctr_width_p-1:0] rd_data_o,
  output logic                   err_orphan_o,
  output logic                   err_overwrite_o
);

  localparam int unsigned out_w = $clog2(tag_els_p + 1);
  localparam int unsigned bin_w = $clog2(hist_bins_p);

  logic [lat_width_p-1:0] now_q;
  logic [tag_els_p-1:0]   valid_q [num_chan_p];
  logic [tag_els_p-1:0]   valid_d [num_chan_p];
  logic [lat_width_p-1:0] start_q [num_chan_p][tag_els_p];

  logic [ctr_width_p-1:0] count_q [num_chan_p];
  logic [ctr_width_p-1:0] count_d [num_chan_p];
  logic [ctr_width_p-1:0] sum_q   [num_chan_p];
  logic [ctr_width_p-1:0] sum_d   [num_chan_p];
  logic [lat_width_p-1:0] max_q   [num_chan_p];
  logic [lat_width_p-1:0] max_d   [num_chan_p];
  logic [out_w-1:0]       out_q   [num_chan_p];
  logic [out_w-1:0]       out_d   [num_chan_p];
  logic [ctr_width_p-1:0] hist_q  [num_chan_p][hist_bins_p];
  logic [ctr_width_p-1:0] hist_d  [num_chan_p][hist_bins_p];

  logic                   err_orphan_q, err_orphan_d;
  logic                   err_overwrite_q, err_overwrite_d;
  logic                   rd_v_q;
  logic [ctr_width_p-1:0] rd_data_q;
  logic [ctr_width_p-1:0] rd_mux;

  logic                   issue_ok, resp_ok, resp_hit, orphan, same_entry, overwrite, stat_upd;
  logic                   rd_chan_ok;
  logic [lat_width_p-1:0] resp_lat;
  logic [bin_w-1:0]       resp_bin;
  logic [ctr_width_p:0]   sum_ext;
  logic [ctr_width_p-1:0] sum_new, count_new, hist_new;
  logic [lat_width_p-1:0] max_new;
  logic [num_chan_p-1:0]  out_inc, out_dec;

  // Requests naming a channel beyond num_chan_p are ignored.
  assign issue_ok   = issue_v_i && (32'(issue_chan_i) < num_chan_p);
  assign resp_ok    = resp_v_i && (32'(resp_chan_i) < num_chan_p);
  assign rd_chan_ok = 32'(rd_chan_i) < num_chan_p;

  assign resp_hit   = resp_ok && valid_q[resp_chan_i][resp_tag_i];
  assign orphan     = resp_ok && !valid_q[resp_chan_i][resp_tag_i];
  assign same_entry = (issue_chan_i == resp_chan_i) && (issue_tag_i == resp_tag_i);
  // A same-entry retire frees the slot before the new issue claims it.
  assign overwrite  = issue_ok && valid_q[issue_chan_i][issue_tag_i] && !(resp_hit && same_entry);
  assign stat_upd   = resp_hit && en_i;

  assign resp_lat = now_q - start_q[resp_chan_i][resp_tag_i];

  // Bin is the index of the highest set bit, clamped to the last bin; L of 0 or 1 lands in bin 0.
  always_comb begin
    resp_bin = '0;
    for (int i = 1; i < lat_width_p; i++) begin
      if (resp_lat[i]) begin
        resp_bin = (32'(i) >= hist_bins_p - 1) ? bin_w'(hist_bins_p - 1) : bin_w'(i);
      end
    end
  end

  always_comb begin
    sum_ext   = {1'b0, sum_q[resp_chan_i]} + (ctr_width_p + 1)'(resp_lat);
    sum_new   = sum_ext[ctr_width_p] ? '1 : sum_ext[ctr_width_p-1:0];
    count_new = (&count_q[resp_chan_i]) ? count_q[resp_chan_i]
                                        : count_q[resp_chan_i] + ctr_width_p'(1);
    hist_new  = (&hist_q[resp_chan_i][resp_bin]) ? hist_q[resp_chan_i][resp_bin]
                                                 : hist_q[resp_chan_i][resp_bin] + ctr_width_p'(1);
    max_new   = (resp_lat > max_q[resp_chan_i]) ? resp_lat : max_q[resp_chan_i];
  end

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    count_d = count_q;
    sum_d   = sum_q;
    max_d   = max_q;
    hist_d  = hist_q;
    out_inc = '0;
    out_dec = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      if (resp_hit && (resp_chan_i == chan_w'(c))) begin
        valid_d[c][resp_tag_i] = 1'b0;
        out_dec[c]             = 1'b1;
      end
      if (issue_ok && (issue_chan_i == chan_w'(c))) begin
        valid_d[c][issue_tag_i] = 1'b1;
        out_inc[c]              = !overwrite;
      end
      if (out_inc[c] && !out_dec[c]) begin
        out_d[c] = out_q[c] + out_w'(1);
      end else if (out_dec[c] && !out_inc[c]) begin
        out_d[c] = out_q[c] - out_w'(1);
      end
      if (clear_i) begin
        count_d[c] = '0;
        sum_d[c]   = '0;
        max_d[c]   = '0;
        for (int b = 0; b < hist_bins_p; b++) begin
          hist_d[c][b] = '0;
        end
      end else if (stat_upd && (resp_chan_i == chan_w'(c))) begin
        count_d[c]          = count_new;
        sum_d[c]            = sum_new;
        max_d[c]            = max_new;
        hist_d[c][resp_bin] = hist_new;
      end
    end
  end

  always_comb begin
    err_orphan_d    = clear_i ? 1'b0 : (err_orphan_q | orphan);
    err_overwrite_d = clear_i ? 1'b0 : (err_overwrite_q | overwrite);
  end

  // Read mux sees pre-update state, so a same-cycle update is not visible to the read.
  always_comb begin
    rd_mux = '0;
    if (rd_chan_ok) begin
      case (rd_field_i)
        field_w'(0): rd_mux = count_q[rd_chan_i];
        field_w'(1): rd_mux = sum_q[rd_chan_i];
        field_w'(2): rd_mux = ctr_width_p'(max_q[rd_chan_i]);
        field_w'(3): rd_mux = ctr_width_p'(out_q[rd_chan_i]);
        default: begin
          for (int b = 0; b < hist_bins_p; b++) begin
            if (rd_field_i == field_w'(4 + b)) begin
              rd_mux = hist_q[rd_chan_i][b];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      now_q           <= '0;
      rd_v_q          <= 1'b0;
      rd_data_q       <= '0;
      err_orphan_q    <= 1'b0;
      err_overwrite_q <= 1'b0;
      for (int c = 0; c < num_chan_p; c++) begin
        valid_q[c] <= '0;
        out_q[c]   <= '0;
        count_q[c] <= '0;
        sum_q[c]   <= '0;
        max_q[c]   <= '0;
        for (int b = 0; b < hist_bins_p; b++) begin
          hist_q[c][b] <= '0;
        end
        for (int t = 0; t < tag_els_p; t++) begin
          start_q[c][t] <= '0;
        end
      end
    end else begin
      now_q           <= now_q + lat_width_p'(1);
      valid_q         <= valid_d;
      out_q           <= out_d;
      count_q         <= count_d;
      sum_q           <= sum_d;
      max_q           <= max_d;
      hist_q          <= hist_d;
      err_orphan_q    <= err_orphan_d;
      err_overwrite_q <= err_overwrite_d;
      rd_v_q          <= rd_v_i;
      if (issue_ok) begin
        start_q[issue_chan_i][issue_tag_i] <= now_q;
      end
      if (rd_v_i) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign rd_v_o          = rd_v_q;
  assign rd_data_o       = rd_data_q;
  assign err_orphan_o    = err_orphan_q;
  assign err_overwrite_o = err_overwrite_q;

endmodule

// File: tb/tb_remote_load_latency_hist.sv
// Bench for remote_load_latency_hist: behavioural model checked every cycle, plus directed
// scenarios with hand-computed read-back values.
module tb_remote_load_latency_hist;

  localparam int NC   = 3;
  localparam int NT   = 32;
  localparam int LW   = 12;
  localparam int CW   = 16;
  localparam int NB   = 8;
  localparam int LMOD = 1 << LW;
  localparam longint MAXC = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          issue_v_i, resp_v_i, en_i, clear_i, rd_v_i;
  logic [1:0]    issue_chan_i, resp_chan_i, rd_chan_i;
  logic [4:0]    issue_tag_i, resp_tag_i;
  logic [3:0]    rd_field_i;
  logic          rd_v_o, err_orphan_o, err_overwrite_o;
  logic [CW-1:0] rd_data_o;

  remote_load_latency_hist #(
    .num_chan_p (NC),
    .tag_els_p  (NT),
    .lat_width_p(LW),
    .ctr_width_p(CW),
    .hist_bins_p(NB)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .issue_v_i      (issue_v_i),
    .issue_chan_i   (issue_chan_i),
    .issue_tag_i    (issue_tag_i),
    .resp_v_i       (resp_v_i),
    .resp_chan_i    (resp_chan_i),
    .resp_tag_i     (resp_tag_i),
    .en_i           (en_i),
    .clear_i        (clear_i),
    .rd_v_i         (rd_v_i),
    .rd_chan_i      (rd_chan_i),
    .rd_field_i     (rd_field_i),
    .rd_v_o         (rd_v_o),
    .rd_data_o      (rd_data_o),
    .err_orphan_o   (err_orphan_o),
    .err_overwrite_o(err_overwrite_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  // Model state
  bit     m_valid [NC][NT];
  int     m_start [NC][NT];
  longint m_count [NC];
  longint m_sum   [NC];
  longint m_max   [NC];
  longint m_out   [NC];
  longint m_hist  [NC][NB];
  bit     m_orph, m_ovw;
  int     m_now;
  bit     e_rdv;
  longint e_rd;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic longint model_field(input int c, input int f);
    if (c >= NC) return 0;
    case (f)
      0: return m_count[c];
      1: return m_sum[c];
      2: return m_max[c];
      3: return m_out[c];
      default: begin
        if (f >= 4 && f < 4 + NB) return m_hist[c][f-4];
        return 0;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      for (int t = 0; t < NT; t++) begin
        m_valid[c][t] = 1'b0;
        m_start[c][t] = 0;
      end
      m_count[c] = 0;
      m_sum[c]   = 0;
      m_max[c]   = 0;
      m_out[c]   = 0;
      for (int b = 0; b < NB; b++) m_hist[c][b] = 0;
    end
    m_orph = 1'b0;
    m_ovw  = 1'b0;
    m_now  = 0;
    e_rdv  = 1'b0;
    e_rd   = 0;
  endtask

  // One clock edge of the specified behaviour: read old state, retire, allocate, clear, tick.
  task automatic model_apply();
    int rc, rt, ic, it, lat, b, x;
    rc = int'(resp_chan_i);
    rt = int'(resp_tag_i);
    ic = int'(issue_chan_i);
    it = int'(issue_tag_i);
    if (rd_v_i) e_rd = model_field(int'(rd_chan_i), int'(rd_field_i));
    e_rdv = rd_v_i;
    if (resp_v_i && rc < NC) begin
      if (m_valid[rc][rt]) begin
        lat = (m_now - m_start[rc][rt] + LMOD) % LMOD;
        m_valid[rc][rt] = 1'b0;
        m_out[rc]--;
        if (en_i) begin
          m_count[rc] = sat(m_count[rc] + 1);
          m_sum[rc]   = sat(m_sum[rc] + lat);
          if (lat > m_max[rc]) m_max[rc] = lat;
          b = 0;
          x = lat;
          while (x > 1) begin
            x = x / 2;
            b++;
          end
          if (b > NB - 1) b = NB - 1;
          m_hist[rc][b] = sat(m_hist[rc][b] + 1);
        end
      end else begin
        m_orph = 1'b1;
      end
    end
    if (issue_v_i && ic < NC) begin
      if (m_valid[ic][it]) m_ovw = 1'b1;
      else m_out[ic]++;
      m_valid[ic][it] = 1'b1;
      m_start[ic][it] = m_now;
    end
    if (clear_i) begin
      for (int c = 0; c < NC; c++) begin
        m_count[c] = 0;
        m_sum[c]   = 0;
        m_max[c]   = 0;
        for (int k = 0; k < NB; k++) m_hist[c][k] = 0;
      end
      m_orph = 1'b0;
      m_ovw  = 1'b0;
    end
    m_now = (m_now + 1) % LMOD;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_v_o", longint'(rd_v_o), longint'(e_rdv));
      check("rd_data_o", longint'(rd_data_o), e_rd);
      check("err_orphan_o", longint'(err_orphan_o), longint'(m_orph));
      check("err_overwrite_o", longint'(err_overwrite_o), longint'(m_ovw));
    end
  end

  task automatic clr_inputs();
    issue_v_i = 1'b0; issue_chan_i = '0; issue_tag_i = '0;
    resp_v_i  = 1'b0; resp_chan_i  = '0; resp_tag_i  = '0;
    rd_v_i    = 1'b0; rd_chan_i    = '0; rd_field_i  = '0;
    clear_i   = 1'b0;
    en_i      = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_apply();
    #1;
    clr_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input int c, input int t);
    issue_v_i = 1'b1; issue_chan_i = 2'(c); issue_tag_i = 5'(t);
  endtask

  task automatic resp(input int c, input int t);
    resp_v_i = 1'b1; resp_chan_i = 2'(c); resp_tag_i = 5'(t);
  endtask

  task automatic rd_chk(input string name, input int c, input int f, input longint exp);
    rd_v_i = 1'b1; rd_chan_i = 2'(c); rd_field_i = 4'(f);
    tick();
    check({name, "_vld"}, longint'(rd_v_o), 1);
    check(name, longint'(rd_data_o), exp);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    clr_inputs();
    reset_i = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rd_v", longint'(rd_v_o), 0);
    check("rst_rd_data", longint'(rd_data_o), 0);
    check("rst_orphan", longint'(err_orphan_o), 0);
    check("rst_overwrite", longint'(err_overwrite_o), 0);
    reset_i = 1'b0;
    rd_chk("rst_count", 0, 0, 0);

    // Single load, L = 7
    issue(0, 5); tick();
    idle(6);
    resp(0, 5); tick();
    rd_chk("t1_count", 0, 0, 1);
    rd_chk("t1_sum", 0, 1, 7);
    rd_chk("t1_max", 0, 2, 7);
    rd_chk("t1_out", 0, 3, 0);
    rd_chk("t1_hist2", 0, 6, 1);

    // 32 outstanding, responses in reverse: L = 64 - 2*tag
    for (int t = 0; t < NT; t++) begin
      issue(1, t); tick();
    end
    rd_chk("t2_out_peak", 1, 3, 32);
    for (int t = NT - 1; t >= 0; t--) begin
      resp(1, t); tick();
    end
    rd_chk("t2_count", 1, 0, 32);
    rd_chk("t2_sum", 1, 1, 1056);
    rd_chk("t2_max", 1, 2, 64);
    rd_chk("t2_hist5", 1, 9, 16);
    rd_chk("t2_hist6", 1, 10, 1);
    rd_chk("t2_out", 1, 3, 0);

    // Orphan, clear, and en_i=0 retire
    resp(2, 3); tick();
    check("t3_orphan", longint'(err_orphan_o), 1);
    rd_chk("t3_count", 2, 0, 0);
    clear_i = 1'b1; issue(2, 9); tick();
    check("t3_orphan_clr", longint'(err_orphan_o), 0);
    rd_chk("t3_ch0_cleared", 0, 0, 0);
    rd_chk("t3_out_kept", 2, 3, 1);
    en_i = 1'b0; resp(2, 9); tick();
    rd_chk("t3_en0_count", 2, 0, 0);
    rd_chk("t3_en0_out", 2, 3, 0);

    // Overwrite: latency from the second issue, L = 5
    issue(0, 1); tick();
    idle(2);
    issue(0, 1); tick();
    check("t4_overwrite", longint'(err_overwrite_o), 1);
    idle(4);
    resp(0, 1); tick();
    rd_chk("t4_count", 0, 0, 1);
    rd_chk("t4_sum", 0, 1, 5);
    clear_i = 1'b1; tick();
    check("t4_overwrite_clr", longint'(err_overwrite_o), 0);

    // Same-cycle retire + reissue (L = 3), then L = 100
    issue(0, 4); tick();
    idle(2);
    resp(0, 4); issue(0, 4); tick();
    idle(99);
    resp(0, 4); tick();
    check("t5_no_ovw", longint'(err_overwrite_o), 0);
    check("t5_no_orph", longint'(err_orphan_o), 0);
    rd_chk("t5_count", 0, 0, 2);
    rd_chk("t5_sum", 0, 1, 103);
    rd_chk("t5_hist1", 0, 5, 1);
    rd_chk("t5_hist6", 0, 10, 1);
    rd_chk("t5_field_oor", 0, 12, 0);
    rd_chk("t5_chan_oor", 3, 0, 0);

    // Sum saturation: 20 loads of L = 4000 on ch2, plus an independent ch0 retire
    issue(0, 7); tick();
    for (int t = 0; t < 20; t++) begin
      issue(2, t);
      if (t == 0) resp(0, 7);
      tick();
    end
    idle(4000 - 20);
    for (int t = 0; t < 20; t++) begin
      resp(2, t); tick();
    end
    rd_chk("t6_sum_sat", 2, 1, 16'hFFFF);
    rd_chk("t6_count", 2, 0, 20);
    rd_chk("t6_max", 2, 2, 4000);
    rd_chk("t6_hist7", 2, 11, 20);
    rd_chk("t6_out", 2, 3, 0);

    // Reset mid-flight: the later response is an orphan
    issue(1, 6); tick();
    idle(3);
    do_reset();
    check("t7_rst_data", longint'(rd_data_o), 0);
    resp(1, 6); tick();
    check("t7_orphan", longint'(err_orphan_o), 1);
    rd_chk("t7_out", 1, 3, 0);
    rd_chk("t7_count", 1, 0, 0);

    idle(2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
